// File: rtl/note_scroll_sched.sv
// Two-lane note highway sequencer: fetches note pairs, scrolls them across two 7-LED rows,
// judges lane presses at the hit column and drives score and feedback lamps. Macro: STREAK_BONUS_EN.
module note_scroll_sched #(
  parameter int CLK_DIV   = 1000000,
  parameter int SONG_LEN  = 32,
  parameter int ADDR_W    = 5,
  parameter int FLASH_CYC = 4000000
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic [1:0]        hit,
  output logic [ADDR_W-1:0] song_addr,
  output logic              song_rd,
  input  logic [1:0]        song_data,
  input  logic              song_valid,
  output logic [6:0]        top_row,
  output logic [6:0]        bottom_row,
  output logic              red_disp,
  output logic              green_disp,
  output logic [7:0]        score,
  output logic              busy,
  output logic              done
);

  localparam int TW = $clog2(CLK_DIV);
  localparam int FW = $clog2(FLASH_CYC + 1);
  localparam int IW = ADDR_W + 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(CLK_DIV - 1);
  localparam logic [FW-1:0] FLASH_LD = FW'(FLASH_CYC);
  localparam logic [IW-1:0] LAST_IDX = IW'(SONG_LEN);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state_q;
  logic [TW-1:0]     tick_q;
  logic [IW-1:0]     idx_q;
  logic [1:0]        note_q;
  logic              pend_q;
  logic [2:0]        drain_q;
  logic [6:0]        top_q, bot_q;
  logic [7:0]        score_q;
  logic [FW-1:0]     red_cnt_q, grn_cnt_q;
  logic              red_q, grn_q;
  logic              start_prev_q, armed_q;
  logic [1:0]        hit_prev_q;
  logic              rd_q, busy_q, done_q;
  logic [ADDR_W-1:0] addr_q;

  logic       busy_st_s, tick_s, start_edge_s, shift_s, red_ld_s, grn_ld_s;
  logic [1:0] hit_edge_s, new_bits_s, bit0_s, good_s, miss_s;
  logic [2:0] inc_s;
  logic [7:0] score_d;
  logic [6:0] top_d, bot_d;

`ifdef STREAK_BONUS_EN
  logic [3:0] streak_q, streak_d, streak1_s, streak2_s;
  logic [2:0] inc1_s, inc0_s;
`endif

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [2:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {6'b000000, b};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

  // Tick, edges, shift decision, per-lane judging and next score/rows
  always_comb begin
    busy_st_s    = (state_q == S_FETCH) || (state_q == S_WAIT) || (state_q == S_DRAIN);
    tick_s       = busy_st_s && (tick_q == TICK_MAX);
    start_edge_s = armed_q && start && !start_prev_q;
    hit_edge_s   = (armed_q && busy_st_s) ? (hit & ~hit_prev_q) : 2'b00;
    shift_s      = 1'b0;
    new_bits_s   = 2'b00;
    case (state_q)
      S_WAIT: begin
        shift_s    = tick_s || pend_q;
        new_bits_s = note_q;
      end
      S_DRAIN: begin
        shift_s    = tick_s;
        new_bits_s = 2'b00;
      end
      default: begin
        shift_s    = 1'b0;
        new_bits_s = 2'b00;
      end
    endcase
    // Judged against pre-shift bit0; a hit note leaving the column is not a miss
    bit0_s   = {top_q[0], bot_q[0]};
    good_s   = hit_edge_s & bit0_s;
    miss_s   = (hit_edge_s & ~bit0_s) | ({2{shift_s}} & bit0_s & ~good_s);
    red_ld_s = |miss_s;
    grn_ld_s = |good_s;
`ifdef STREAK_BONUS_EN
    streak1_s = streak_q + {3'b000, good_s[1]};
    inc1_s    = good_s[1] ? ((streak1_s[2:0] == 3'd0) ? 3'd2 : 3'd1) : 3'd0;
    streak2_s = streak1_s + {3'b000, good_s[0]};
    inc0_s    = good_s[0] ? ((streak2_s[2:0] == 3'd0) ? 3'd2 : 3'd1) : 3'd0;
    inc_s     = inc1_s + inc0_s;
    streak_d  = red_ld_s ? 4'd0 : streak2_s;
`else
    inc_s = {2'b00, good_s[1]} + {2'b00, good_s[0]};
`endif
    score_d = sat_add8(score_q, inc_s);
    top_d   = shift_s ? {new_bits_s[1], top_q[6:1]} : {top_q[6:1], top_q[0] & ~good_s[1]};
    bot_d   = shift_s ? {new_bits_s[0], bot_q[6:1]} : {bot_q[6:1], bot_q[0] & ~good_s[0]};
  end

  // Sequencer FSM with tick counter, lamps, score and row registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= S_IDLE;
      tick_q       <= {TW{1'b0}};
      idx_q        <= {IW{1'b0}};
      note_q       <= 2'b00;
      pend_q       <= 1'b0;
      drain_q      <= 3'd0;
      top_q        <= 7'd0;
      bot_q        <= 7'd0;
      score_q      <= 8'd0;
      red_cnt_q    <= {FW{1'b0}};
      grn_cnt_q    <= {FW{1'b0}};
      red_q        <= 1'b0;
      grn_q        <= 1'b0;
      start_prev_q <= 1'b0;
      hit_prev_q   <= 2'b00;
      armed_q      <= 1'b0;
      rd_q         <= 1'b0;
      addr_q       <= {ADDR_W{1'b0}};
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef STREAK_BONUS_EN
      streak_q     <= 4'd0;
`endif
    end else begin
      start_prev_q <= start;
      hit_prev_q   <= hit;
      armed_q      <= 1'b1;
      tick_q       <= (busy_st_s && !tick_s) ? tick_q + TW'(1) : {TW{1'b0}};
      if (red_ld_s) red_cnt_q <= FLASH_LD;
      else if (red_cnt_q != {FW{1'b0}}) red_cnt_q <= red_cnt_q - FW'(1);
      else red_cnt_q <= red_cnt_q;
      if (grn_ld_s) grn_cnt_q <= FLASH_LD;
      else if (grn_cnt_q != {FW{1'b0}}) grn_cnt_q <= grn_cnt_q - FW'(1);
      else grn_cnt_q <= grn_cnt_q;
      red_q   <= red_ld_s || (red_cnt_q > FW'(1));
      grn_q   <= grn_ld_s || (grn_cnt_q > FW'(1));
      score_q <= score_d;
`ifdef STREAK_BONUS_EN
      streak_q <= streak_d;
`endif
      top_q <= busy_st_s ? top_d : 7'd0;
      bot_q <= busy_st_s ? bot_d : 7'd0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_edge_s) begin
            state_q  <= S_FETCH;
            score_q  <= 8'd0;
`ifdef STREAK_BONUS_EN
            streak_q <= 4'd0;
`endif
            idx_q    <= {IW{1'b0}};
            pend_q   <= 1'b0;
            rd_q     <= 1'b1;
            addr_q   <= {ADDR_W{1'b0}};
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
          end
        end
        S_FETCH: begin
          if (tick_s) pend_q <= 1'b1;
          if (song_valid) begin
            note_q  <= song_data;
            idx_q   <= idx_q + IW'(1);
            rd_q    <= 1'b0;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (shift_s) begin
            pend_q <= 1'b0;
            if (idx_q == LAST_IDX) begin
              state_q <= S_DRAIN;
              drain_q <= 3'd7;
            end else begin
              state_q <= S_FETCH;
              rd_q    <= 1'b1;
              addr_q  <= idx_q[ADDR_W-1:0];
            end
          end
        end
        S_DRAIN: begin
          if (shift_s) begin
            drain_q <= drain_q - 3'd1;
            if (drain_q == 3'd1) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          rd_q    <= 1'b0;
        end
      endcase
    end
  end

  assign song_addr  = addr_q;
  assign song_rd    = rd_q;
  assign top_row    = top_q;
  assign bottom_row = bot_q;
  assign red_disp   = red_q;
  assign green_disp = grn_q;
  assign score      = score_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_note_scroll_sched.sv
// Randomized bench for note_scroll_sched against a game-level reference model with a song-store responder.
module tb_note_scroll_sched;
  localparam int CLK_DIV   = 4;
  localparam int SONG_LEN  = 140;
  localparam int ADDR_W    = 8;
  localparam int FLASH_CYC = 12;
  localparam int P_IDLE = 0, P_FETCH = 1, P_WAIT = 2, P_DRAIN = 3, P_DONE = 4;

  logic clk = 1'b0, n_rst = 1'b0, start = 1'b0, song_valid = 1'b0;
  logic [1:0] hit = 2'b00, song_data = 2'b00;
  logic [ADDR_W-1:0] song_addr;
  logic song_rd, red_disp, green_disp, busy, done;
  logic [6:0] top_row, bottom_row;
  logic [7:0] score;

  int n_tests = 0, n_fail = 0;
  logic [1:0] notes [SONG_LEN];
  int mem_cnt = -1, lat_lo = 1, lat_hi = 3;

  int m_phase, m_bc, m_fetched, m_drain, m_score, m_red, m_grn, m_streak, m_addr;
  bit m_pend, m_rd, m_armed, m_pst;
  bit [1:0] m_ph, m_next;
  bit [6:0] m_row [2];

  note_scroll_sched #(.CLK_DIV(CLK_DIV), .SONG_LEN(SONG_LEN), .ADDR_W(ADDR_W), .FLASH_CYC(FLASH_CYC)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .hit(hit), .song_addr(song_addr), .song_rd(song_rd),
    .song_data(song_data), .song_valid(song_valid), .top_row(top_row), .bottom_row(bottom_row),
    .red_disp(red_disp), .green_disp(green_disp), .score(score), .busy(busy), .done(done));

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = P_IDLE; m_bc = 0; m_fetched = 0; m_drain = 0; m_score = 0; m_red = 0; m_grn = 0;
    m_streak = 0; m_addr = 0; m_pend = 0; m_rd = 0; m_armed = 0; m_pst = 0; m_ph = 2'b00;
    m_next = 2'b00; m_row[0] = 7'd0; m_row[1] = 7'd0;
  endtask

  // One clock of game behaviour given the inputs presented before the edge
  task automatic model_step(input logic st, input logic [1:0] hv, input logic vld, input logic [1:0] dat);
    bit st_e, in_play, tick, shift, red_ev, grn_ev;
    bit [1:0] h_e, nb;
    int inc;
    st_e = m_armed && st && !m_pst;
    h_e = m_armed ? (hv & ~m_ph) : 2'b00;
    m_armed = 1; m_pst = st; m_ph = hv;
    in_play = (m_phase == P_FETCH) || (m_phase == P_WAIT) || (m_phase == P_DRAIN);
    tick = in_play && (m_bc % CLK_DIV == CLK_DIV - 1);
    shift = (m_phase == P_WAIT && (tick || m_pend)) || (m_phase == P_DRAIN && tick);
    nb = (m_phase == P_WAIT) ? m_next : 2'b00;
    inc = 0; red_ev = 0; grn_ev = 0;
    if (in_play) begin
      for (int l = 1; l >= 0; l--) begin
        if (h_e[l] && m_row[l][0]) begin
          m_row[l][0] = 1'b0;
          grn_ev = 1;
          m_streak = (m_streak + 1) % 16;
`ifdef STREAK_BONUS_EN
          inc += (m_streak % 8 == 0) ? 2 : 1;
`else
          inc += 1;
`endif
        end else if (h_e[l]) red_ev = 1;
        else if (shift && m_row[l][0]) red_ev = 1;
      end
    end
    if (red_ev) m_streak = 0;
    m_score = (m_score + inc > 255) ? 255 : m_score + inc;
    m_red = red_ev ? FLASH_CYC : ((m_red > 0) ? m_red - 1 : 0);
    m_grn = grn_ev ? FLASH_CYC : ((m_grn > 0) ? m_grn - 1 : 0);
    if (shift) for (int l = 0; l < 2; l++) m_row[l] = {nb[l], m_row[l][6:1]};
    if (in_play) m_bc++;
    case (m_phase)
      P_IDLE, P_DONE: begin
        m_row[0] = 7'd0; m_row[1] = 7'd0; m_bc = 0;
        if (st_e) begin
          m_phase = P_FETCH; m_score = 0; m_streak = 0; m_fetched = 0;
          m_pend = 0; m_rd = 1; m_addr = 0;
        end
      end
      P_FETCH: begin
        if (tick) m_pend = 1;
        if (vld) begin
          m_next = dat; m_fetched++; m_rd = 0; m_phase = P_WAIT;
        end
      end
      P_WAIT: if (shift) begin
        m_pend = 0;
        if (m_fetched == SONG_LEN) begin
          m_phase = P_DRAIN; m_drain = 7;
        end else begin
          m_phase = P_FETCH; m_rd = 1; m_addr = m_fetched;
        end
      end
      P_DRAIN: if (shift) begin
        m_drain--;
        if (m_drain == 0) m_phase = P_DONE;
      end
      default: m_phase = P_IDLE;
    endcase
  endtask

  task automatic check_outputs();
    bit in_play;
    in_play = (m_phase == P_FETCH) || (m_phase == P_WAIT) || (m_phase == P_DRAIN);
    check_value("top_row", 32'(top_row), 32'(m_row[1]));
    check_value("bottom_row", 32'(bottom_row), 32'(m_row[0]));
    check_value("score", 32'(score), 32'(m_score));
    check_value("red_disp", 32'(red_disp), 32'(m_red > 0));
    check_value("green_disp", 32'(green_disp), 32'(m_grn > 0));
    check_value("busy", 32'(busy), 32'(in_play));
    check_value("done", 32'(done), 32'(m_phase == P_DONE));
    check_value("song_rd", 32'(song_rd), 32'(m_rd));
    check_value("song_addr", 32'(song_addr), 32'(m_addr % (1 << ADDR_W)));
  endtask

  task automatic check_all_zero(input string tag);
    check_value(tag, {top_row, bottom_row, score, red_disp, green_disp, busy, done, song_rd, 3'b000},
                32'd0);
    check_value({tag, "_addr"}, 32'(song_addr), 32'd0);
  endtask

  task automatic run_cycle(input logic st, input logic [1:0] hv);
    logic vld;
    logic [1:0] dat;
    vld = 1'b0; dat = 2'b00;
    if (mem_cnt < 0 && song_rd === 1'b1) mem_cnt = $urandom_range(lat_hi - 1, lat_lo - 1);
    if (mem_cnt == 0) begin
      vld = 1'b1;
      if (int'(song_addr) < SONG_LEN) dat = notes[song_addr];
      mem_cnt = -1;
    end else if (mem_cnt > 0) mem_cnt--;
    start = st; hit = hv; song_valid = vld; song_data = dat;
    model_step(st, hv, vld, dat);
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  function automatic logic [1:0] pick_hits(input int mode);
    logic [1:0] h;
    h = 2'b00;
    for (int l = 0; l < 2; l++) begin
      if (mode == 1) h[l] = ($urandom_range(4, 0) == 0);
      else if (mode == 2) h[l] = m_row[l][0] && !hit[l];
      else h[l] = 1'b0;
    end
    return h;
  endfunction

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) run_cycle(1'b0, 2'($urandom_range(3, 0)));
    run_cycle(1'b0, 2'b00);
  endtask

  task automatic play_game(input int hmode, input int nmode, input int max_cyc);
    int n;
    for (int i = 0; i < SONG_LEN; i++) notes[i] = (nmode == 1) ? 2'b11 : 2'($urandom_range(3, 0));
    run_cycle(1'b1, 2'b00);
    n = 0;
    while (m_phase != P_DONE && n < max_cyc) begin
      run_cycle((hmode == 1) && ($urandom_range(40, 0) == 0), pick_hits(hmode));
      n++;
    end
    check_value("game_timeout", 32'(n < max_cyc), 32'd1);
    check_value("game_done", 32'(done), 32'd1);
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    n_rst = 1'b1;
    idle_cycles(6);

    lat_lo = 1; lat_hi = 3;
    play_game(0, 0, 6000);
    check_value("no_hit_score", 32'(score), 32'd0);
    idle_cycles(4);

    lat_lo = 1; lat_hi = 12;
    play_game(1, 0, 6000);
    idle_cycles(4);

    lat_lo = 8; lat_hi = 12;
    play_game(2, 0, 6000);
    idle_cycles(4);

    lat_lo = 1; lat_hi = 2;
    play_game(2, 1, 6000);
    check_value("saturated_score", 32'(score), 32'd255);
    idle_cycles(4);

    lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < SONG_LEN; i++) notes[i] = 2'($urandom_range(3, 0));
    run_cycle(1'b1, 2'b00);
    for (int i = 0; i < 150; i++) run_cycle(1'b0, pick_hits(2));
    n_rst = 1'b0;
    #1;
    check_all_zero("midreset_now");
    model_reset();
    mem_cnt = -1; start = 1'b0; hit = 2'b00; song_valid = 1'b0; song_data = 2'b00;
    @(negedge clk);
    check_all_zero("midreset_held");
    n_rst = 1'b1;
    idle_cycles(3);
    play_game(2, 0, 6000);
    idle_cycles(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/note_scroll_sched.md
Name: note_scroll_sched

Overview:
- Game sequencer for the two-lane note highway: fetches song notes from a song store via a req/valid handshake and scrolls them across the top and bottom 7-LED rows at a fixed tempo.
- Judges lane button presses against the hit column and maintains score and the red/green feedback lamps.
- Sits between the song storage block and the row/lamp/seven-segment drivers inside the game top level.

Parameters:
CLK_DIV, 1000000, clocks per scroll step (>=4)
SONG_LEN, 32, notes per song (>=1)
ADDR_W, 5, song address width, 2**ADDR_W >= SONG_LEN
FLASH_CYC, 4000000, clocks a feedback lamp stays lit after an event

Ports:
clk  in  1  system clock
n_rst  in  1  reset, asynchronous, active-low
start  in  1  synchronized start request; rising edge acts
hit  in  2  synchronized lane buttons, [1]=top, [0]=bottom; rising edge acts
song_addr  out  ADDR_W  note index being fetched
song_rd  out  1  fetch request
song_data  in  2  note pair, [1]=top, [0]=bottom
song_valid  in  1  song_data valid, one-cycle pulse, any latency >=1
top_row  out  7  top lane LEDs, bit0 = hit column
bottom_row  out  7  bottom lane LEDs, bit0 = hit column
red_disp  out  1  miss/wrong-press lamp
green_disp  out  1  good-hit lamp
score  out  8  saturating hit score
busy  out  1  high in FETCH/WAIT/DRAIN
done  out  1  high in DONE

Behaviour:
- Reset: all outputs 0, state IDLE, tick counter 0, note index 0, all flags cleared. Applies mid-operation immediately.
- Tick counter:
  - Counts 0..CLK_DIV-1 only while busy; tick = 1 cycle at wrap.
  - Cleared in IDLE/DONE.
- States:
  - IDLE: rows 0. Start edge -> clear score, index, rows; go to FETCH.
  - FETCH: song_rd=1, song_addr=index, held until song_valid. Cycle with valid: latch song_data into next_note, index+1, song_rd drops next cycle, go to WAIT.
  - WAIT: on tick (or pending tick), shift. If index==SONG_LEN go to DRAIN with drain count 7, else go to FETCH.
  - DRAIN: on tick, shift in 0 and decrement. After the 7th shift go to DONE.
  - DONE: done=1, rows 0, score held. Start edge -> restart as from IDLE.
- Shift: row <= {new_bit, row[6:1]} per lane; new_bit comes from next_note (0 in DRAIN).
- Tick arriving in FETCH sets the pending flag. Shift occurs the cycle after the note is latched; the pending flag is cleared then.
- Judging (per lane, independent):
  - Hit edge with row bit0=1: score+1 (saturate at 255), clear bit0, green timer loaded.
  - Hit edge with bit0=0: red timer loaded, score unchanged.
  - Shift while bit0=1 (unhit note leaving): red timer loaded.
- Edge coincident with a shift is judged against the pre-shift bit0.
- Both lanes scoring in the same cycle -> score+2 (saturating).
- Lamps: each lamp is high while its FLASH_CYC down-counter is nonzero; a reload restarts it. Red and green may both be high.
- Hits and start edges are ignored outside busy and IDLE/DONE respectively. Start while busy is ignored.
- Edge detectors register their input; the first cycle after reset never detects an edge.

Optional Feature:
- Macro STREAK_BONUS_EN.
- Defined: 4-bit streak counter increments per good hit and clears on miss or wrong press. A good hit that brings the streak to a multiple of 8 scores +2 instead of +1. Both-lane bonus cases sum, saturating.
- Undefined: no streak logic; every good hit scores +1.

Test Plan:
- CLK_DIV=4, SONG_LEN=2, notes {2'b10, 2'b01}, valid 2 cycles after rd, no hits. Required response:
  - top_row = 7'b1000000 after shift 1.
  - 7 shifts later, top bit0 leaves and red lights.
  - done after 9 shifts total; score=0.
- Same song, pulse hit[1] while top_row[0]=1 -> score=1, green high FLASH_CYC cycles, top_row[0] cleared that cycle, no red for that note.
- hit[0] while bottom_row[0]=0 -> red high, score unchanged.
- song_valid delayed 10 cycles (> CLK_DIV) -> pending tick; shift occurs the cycle after latch; no note lost; final shift count unchanged.
- Assert n_rst low during PLAY for one cycle -> all outputs 0 immediately; start edge replays the song from address 0.
- score preloaded near saturation via 255 hits, then one double-lane hit -> score stays 255; with STREAK_BONUS_EN, 8th consecutive hit adds 2.
